spi_master_sequencer: RTL

// - Transaction front-end directly upstream of the SPI master interface: buffers requests, drives its config/start/din, collects dout.
// - Requests are {cfg, tx word}: cfg reprogrammed only when it differs from the last applied value.
// - Each completed transfer's received word is queued for the consumer.

---
 rtl/spi_master_sequencer_pkg.sv | 14 +
 rtl/spi_seq_fifo.sv | 43 ++++
 rtl/spi_master_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/spi_master_sequencer_pkg.sv
// Shared definitions for the SPI master sequencer: FSM state encodings.
// cfg layout is {cpol, cpha, width[L-1:0]}, i.e. CPOL at bit L+1, CPHA at bit L.
package spi_master_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CFG      = 3'd1,
    ST_CFG_WAIT = 3'd2,
    ST_START    = 3'd3,
    ST_BUSY     = 3'd4,
    ST_STORE    = 3'd5
  } seq_state_e;

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry an extra MSB so
// full and empty can be told apart when the index bits match.
module spi_seq_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH_LOG = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] pop_data
);

  logic [WIDTH-1:0]   mem [2**DEPTH_LOG];
  logic [DEPTH_LOG:0] wr_ptr, rd_ptr;
  logic               do_push, do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[DEPTH_LOG] != rd_ptr[DEPTH_LOG]) &&
                    (wr_ptr[DEPTH_LOG-1:0] == rd_ptr[DEPTH_LOG-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Head reads as zero when empty so the consumer never sees stale storage.
  assign pop_data = empty ? '0 : mem[rd_ptr[DEPTH_LOG-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (DEPTH_LOG+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (DEPTH_LOG+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG-1:0]] <= push_data;
  end

endmodule

// File: rtl/spi_master_sequencer.sv
// Request sequencer in front of an SPI master: queues {cfg, word} requests,
// reprograms cfg only on change, queues received words. Optional watchdog: SPI_SEQ_TIMEOUT_EN.
module spi_master_sequencer
  import spi_master_sequencer_pkg::*;
#(
  parameter int SPI_MAX_WIDTH_LOG = 4,
  parameter int FIFO_DEPTH_LOG    = 2,
  parameter int TIMEOUT_LOG       = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [SPI_MAX_WIDTH_LOG+1:0]      req_cfg,
  input  logic [(2**SPI_MAX_WIDTH_LOG)-1:0] req_data,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [(2**SPI_MAX_WIDTH_LOG)-1:0] rsp_data,
  output logic                              busy,
  output logic                              err_timeout,
  output logic                              config_req,
  output logic [SPI_MAX_WIDTH_LOG+1:0]      config_data,
  output logic                              spi_start,
  input  logic                              spi_finish,
  output logic [(2**SPI_MAX_WIDTH_LOG)-1:0] spi_din,
  input  logic [(2**SPI_MAX_WIDTH_LOG)-1:0] spi_dout
);

  localparam int W  = 2**SPI_MAX_WIDTH_LOG;
  localparam int CW = SPI_MAX_WIDTH_LOG + 2;

  seq_state_e      state_q, state_d;
  logic            tx_push, tx_pop, tx_full, tx_empty;
  logic [CW+W-1:0] tx_head;
  logic [CW-1:0]   tx_cfg, cur_cfg, last_cfg;
  logic [W-1:0]    tx_data, rx_word;
  logic            last_cfg_valid;
  logic            rx_push, rx_full, rx_empty;
  logic            wd_expire;

  // A request offered during reset would be flushed, so it is not accepted.
  assign req_ready = !tx_full && !rst;
  assign tx_push   = req_valid && req_ready;
  assign {tx_cfg, tx_data} = tx_head;
  assign rsp_valid = !rx_empty;
  assign busy      = (state_q != ST_IDLE) || !tx_empty;

  spi_seq_fifo #(.WIDTH(CW + W), .DEPTH_LOG(FIFO_DEPTH_LOG)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data ({req_cfg, req_data}),
    .pop       (tx_pop),
    .full      (tx_full),
    .empty     (tx_empty),
    .pop_data  (tx_head)
  );

  spi_seq_fifo #(.WIDTH(W), .DEPTH_LOG(FIFO_DEPTH_LOG)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_word),
    .pop       (rsp_ready),
    .full      (rx_full),
    .empty     (rx_empty),
    .pop_data  (rsp_data)
  );

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam logic [TIMEOUT_LOG-1:0] WD_LAST = TIMEOUT_LOG'(2**TIMEOUT_LOG - 2);

  logic [TIMEOUT_LOG-1:0] wd_cnt;
  logic                   err_q;

  // wd_cnt is 0 in the first BUSY cycle, so WD_LAST marks the (2**TIMEOUT_LOG-1)th.
  assign wd_expire   = (state_q == ST_BUSY) && !spi_finish && (wd_cnt == WD_LAST);
  assign err_timeout = err_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != ST_BUSY) wd_cnt <= '0;
    else                           wd_cnt <= wd_cnt + TIMEOUT_LOG'(1);
    if (rst)            err_q <= 1'b0;
    else if (wd_expire) err_q <= 1'b1;
  end
`else
  assign wd_expire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          state_d = (!last_cfg_valid || tx_cfg != last_cfg) ? ST_CFG : ST_START;
        end
      end
      ST_CFG:      state_d = ST_CFG_WAIT;
      ST_CFG_WAIT: state_d = ST_START;
      ST_START:    state_d = ST_BUSY;
      ST_BUSY: begin
        if (spi_finish)     state_d = ST_STORE;
        else if (wd_expire) state_d = ST_IDLE;
      end
      ST_STORE: begin
        if (!rx_full) begin
          rx_push = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are registered off the state, so they trail the state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      last_cfg_valid <= 1'b0;
      config_req     <= 1'b0;
      config_data    <= '0;
      spi_start      <= 1'b0;
      spi_din        <= '0;
    end else begin
      state_q    <= state_d;
      config_req <= (state_q == ST_CFG);
      spi_start  <= (state_q == ST_START);
      if (state_q == ST_CFG) begin
        config_data    <= cur_cfg;
        last_cfg_valid <= 1'b1;
      end
      if (tx_pop)    spi_din        <= tx_data;
      if (wd_expire) last_cfg_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_pop)                            cur_cfg  <= tx_cfg;
    if (state_q == ST_CFG)                 last_cfg <= cur_cfg;
    if (state_q == ST_BUSY && spi_finish)  rx_word  <= spi_dout;
  end

endmodule
